// File: rtl/packet_filler.sv
// +-----------------------------------------------------------------------------+
// | Module      : packet_filler                                                 |
// | Description : Packs a 32-bit big-endian stream packet into one buffer from  |
// |               word 0 and reports its byte length. Macro PACKET_FILLER_TKEEP_EN|
// |               adds s_tkeep for a partial last beat.                         |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

module packet_filler #(
   parameter int BYTE_ADDR_WIDTH = 12,
   parameter int ADDR_WIDTH      = BYTE_ADDR_WIDTH - 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [31:0]              s_tdata,
   input  logic                     s_tvalid,
   output logic                     s_tready,
   input  logic                     s_tlast,
`ifdef PACKET_FILLER_TKEEP_EN
   input  logic [3:0]               s_tkeep,
`endif
   input  logic                     buf_rdy,
   output logic [ADDR_WIDTH-1:0]    wr_addr,
   output logic [31:0]              idata,
   output logic                     wr_en,
   output logic                     pkt_valid,
   output logic [BYTE_ADDR_WIDTH:0] pkt_len,
   output logic                     pkt_trunc,
   input  logic                     pkt_ack
);

   localparam logic [BYTE_ADDR_WIDTH:0] c_MAX_LEN = {1'b1, {BYTE_ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0]      c_ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic [ADDR_WIDTH:0]        r_word_cnt;
   logic                       r_trunc;
   logic [BYTE_ADDR_WIDTH:0]   r_len;
   logic                       w_accept;
   logic                       w_fill_entry;
   logic                       w_room;
   logic [2:0]                 w_last_bytes;
   logic [BYTE_ADDR_WIDTH:0]   w_len;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      s_tready    = 1'b0;
      pkt_valid   = 1'b0;
      case (r_state)
         ST_IDLE: if (buf_rdy) w_state_nxt = ST_FILL;
         ST_FILL: begin
            s_tready = 1'b1;
            if (s_tvalid && s_tlast) w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            pkt_valid = 1'b1;
            if (pkt_ack) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_accept     = s_tvalid & s_tready;
   assign w_fill_entry = (r_state == ST_IDLE) & buf_rdy;
   // Counter MSB set means all 2^ADDR_WIDTH words are used.
   assign w_room       = ~r_word_cnt[ADDR_WIDTH];

`ifdef PACKET_FILLER_TKEEP_EN
   // Only the leading run of ones from bit 3 counts.
   always_comb begin
      casez (s_tkeep)
         4'b0???: w_last_bytes = 3'd0;
         4'b10??: w_last_bytes = 3'd1;
         4'b110?: w_last_bytes = 3'd2;
         4'b1110: w_last_bytes = 3'd3;
         default: w_last_bytes = 3'd4;
      endcase
   end
`else
   assign w_last_bytes = 3'd4;
`endif

   assign w_len = (r_trunc | ~w_room) ? c_MAX_LEN
                : {r_word_cnt, 2'b00} + {{(BYTE_ADDR_WIDTH-2){1'b0}}, w_last_bytes};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         idata      <= '0;
         r_word_cnt <= '0;
         r_trunc    <= 1'b0;
         r_len      <= '0;
      end else begin
         wr_en <= 1'b0;
         if (w_fill_entry) begin
            r_word_cnt <= '0;
            r_trunc    <= 1'b0;
         end
         if (w_accept) begin
            if (w_room) begin
               wr_en      <= 1'b1;
               wr_addr    <= r_word_cnt[ADDR_WIDTH-1:0];
               idata      <= s_tdata;
               r_word_cnt <= r_word_cnt + c_ONE;
            end else begin
               r_trunc <= 1'b1;
            end
            if (s_tlast) r_len <= w_len;
         end
      end
   end

   assign pkt_len   = r_len;
   assign pkt_trunc = r_trunc;

endmodule

`default_nettype wire

// File: tb/tb_packet_filler.sv
// Directed bench for packet_filler with a per-beat reference model and literal checks.
`default_nettype none

module tb_packet_filler;
   localparam int DEPTH  = 1024;
   localparam int MAXLEN = 4096;
   localparam int LIMIT  = 200;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] s_tdata = '0;
   logic        s_tvalid = 1'b0;
   logic        s_tready;
   logic        s_tlast = 1'b0;
   logic [3:0]  s_tkeep = 4'hF;
   logic        buf_rdy = 1'b0;
   logic [9:0]  wr_addr;
   logic [31:0] idata;
   logic        wr_en;
   logic        pkt_valid;
   logic [12:0] pkt_len;
   logic        pkt_trunc;
   logic        pkt_ack = 1'b0;

   packet_filler #(.BYTE_ADDR_WIDTH(12)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
`ifdef PACKET_FILLER_TKEEP_EN
      .s_tkeep(s_tkeep),
`endif
      .buf_rdy(buf_rdy), .wr_addr(wr_addr), .idata(idata), .wr_en(wr_en),
      .pkt_valid(pkt_valid), .pkt_len(pkt_len), .pkt_trunc(pkt_trunc), .pkt_ack(pkt_ack)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
   endtask

   task automatic fail_timeout(input string name);
      checks++;
      $display("FAIL %s: actual=timeout required=event within %0d cycles", name, LIMIT);
   endtask

   function automatic int keep_bytes(input logic [3:0] k);
      int n;
      n = 4;
`ifdef PACKET_FILLER_TKEEP_EN
      n = 0;
      for (int i = 3; i >= 0; i--) begin
         if (!k[i]) break;
         n++;
      end
`endif
      return n;
   endfunction

   // Reference model: beat index within packet decides address, drop, and length.
   int          m_idx;
   bit          m_exp_wr;
   int          m_exp_addr;
   logic [31:0] m_exp_data;
   bit          m_pending;
   int          m_exp_len;
   bit          m_exp_trunc;
   int          cyc = 0;

   always @(posedge clk) cyc++;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_idx = 0; m_exp_wr = 0; m_pending = 0; m_exp_len = 0; m_exp_trunc = 0;
      end else begin
         m_exp_wr = 0;
         if (m_pending && pkt_ack) m_pending = 0;
         if (s_tvalid && s_tready) begin
            if (m_idx < DEPTH) begin
               m_exp_wr = 1; m_exp_addr = m_idx; m_exp_data = s_tdata;
            end
            m_idx++;
            if (s_tlast) begin
               m_pending   = 1;
               m_exp_trunc = (m_idx > DEPTH);
               m_exp_len   = m_exp_trunc ? MAXLEN : 4 * (m_idx - 1) + keep_bytes(s_tkeep);
               m_idx       = 0;
            end
         end
      end
   end

   int          log_addr[$];
   logic [31:0] log_data[$];
   int          log_cyc[$];
   int          pulse_len[$];
   bit          prev_valid = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_s_tready", s_tready, 0);
         check("rst_wr_en", wr_en, 0);
         check("rst_wr_addr", wr_addr, 0);
         check("rst_idata", idata, 0);
         check("rst_pkt_valid", pkt_valid, 0);
         check("rst_pkt_len", pkt_len, 0);
         check("rst_pkt_trunc", pkt_trunc, 0);
         prev_valid = 0;
      end else begin
         check("wr_en", wr_en, m_exp_wr);
         if (wr_en && m_exp_wr) begin
            check("wr_addr", wr_addr, m_exp_addr);
            check("idata", idata, m_exp_data);
         end
         if (wr_en) begin
            log_addr.push_back(int'(wr_addr));
            log_data.push_back(idata);
            log_cyc.push_back(cyc);
         end
         check("pkt_valid", pkt_valid, m_pending);
         if (pkt_valid && m_pending) begin
            check("pkt_len", pkt_len, m_exp_len);
            check("pkt_trunc", pkt_trunc, m_exp_trunc);
         end
         if (pkt_valid && !prev_valid) pulse_len.push_back(int'(pkt_len));
         prev_valid = pkt_valid;
         check("ready_while_valid", s_tready & pkt_valid, 0);
      end
   end

   // Drive point: just after the falling edge, after the compare process ran.
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_logs();
      log_addr.delete(); log_data.delete(); log_cyc.delete(); pulse_len.delete();
   endtask

   task automatic send_beat(input logic [31:0] data, input logic last, input logic [3:0] keep);
      int n;
      s_tdata = data; s_tvalid = 1'b1; s_tlast = last; s_tkeep = keep;
      n = 0;
      while (!s_tready && n < LIMIT) begin tick(); n++; end
      if (!s_tready) begin
         fail_timeout("send_beat");
      end else begin
         tick();
      end
      s_tvalid = 1'b0; s_tlast = 1'b0;
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!pkt_valid && n < LIMIT) begin tick(); n++; end
      if (!pkt_valid) fail_timeout("wait_pkt_valid");
   endtask

   task automatic do_ack();
      pkt_ack = 1'b1;
      tick();
      pkt_ack = 1'b0;
      check("valid_drop_after_ack", pkt_valid, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      check("idle_no_ready", s_tready, 0);

      // Backpressure: no buffer, valid held
      clear_logs();
      s_tvalid = 1'b1; s_tdata = 32'hA000_0000; s_tlast = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_ready_low", s_tready, 0);
         check("bp_no_write", wr_en, 0);
      end
      buf_rdy = 1'b1;
      tick();
      check("bp_ready_rise", s_tready, 1);
      tick();
      check("bp_first_wr_en", wr_en, 1);
      check("bp_first_addr", wr_addr, 0);
      s_tvalid = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         repeat ($urandom_range(0, 3)) tick();
         send_beat(32'hA000_0000 + i, (i == 5), 4'hF);
      end
      wait_valid();
      check("bp_len", pkt_len, 24);
      check("bp_nwrites", log_addr.size(), 6);
      for (int i = 0; i < 6 && i < log_addr.size(); i++) check("bp_addr_seq", log_addr[i], i);
      do_ack();

      // Basic 3-beat packet
      tick();
      clear_logs();
      send_beat(32'h1122_3344, 1'b0, 4'hF);
      send_beat(32'h5566_7788, 1'b0, 4'hF);
      send_beat(32'h99AA_BBCC, 1'b1, 4'hF);
      wait_valid();
      check("basic_len", pkt_len, 12);
      check("basic_trunc", pkt_trunc, 0);
      check("basic_nwrites", log_addr.size(), 3);
      if (log_addr.size() == 3) begin
         check("basic_addr0", log_addr[0], 0);
         check("basic_addr2", log_addr[2], 2);
         check("basic_data0", log_data[0], 32'h1122_3344);
         check("basic_data1", log_data[1], 32'h5566_7788);
         check("basic_data2", log_data[2], 32'h99AA_BBCC);
         check("basic_consecutive", log_cyc[2] - log_cyc[0], 2);
      end
      repeat (3) begin
         tick();
         check("basic_hold_ready", s_tready, 0);
      end
      do_ack();
      check("ack_ready_m1", s_tready, 0);
      tick();
      check("ack_ready_m2", s_tready, 1);

      // Overflow: 1030 beats into a 1024-word buffer
      clear_logs();
      for (int i = 0; i < 1030; i++) send_beat(32'(i), (i == 1029), 4'hF);
      wait_valid();
      check("ovf_nwrites", log_addr.size(), 1024);
      if (log_addr.size() > 0) check("ovf_last_addr", log_addr[log_addr.size()-1], 1023);
      check("ovf_len", pkt_len, 4096);
      check("ovf_trunc", pkt_trunc, 1);
      do_ack();

`ifdef PACKET_FILLER_TKEEP_EN
      send_beat(32'hC0C1_C2C3, 1'b0, 4'hF);
      send_beat(32'hC4C5_C6C7, 1'b1, 4'b1100);
      wait_valid();
      check("tkeep_1100_len", pkt_len, 6);
      do_ack();
      send_beat(32'hD0D1_D2D3, 1'b0, 4'hF);
      send_beat(32'hD4D5_D6D7, 1'b1, 4'b1010);
      wait_valid();
      check("tkeep_1010_len", pkt_len, 5);
      do_ack();
`endif

      // Reset mid-packet
      send_beat(32'hE000_0001, 1'b0, 4'hF);
      send_beat(32'hE000_0002, 1'b0, 4'hF);
      rst_n = 1'b0;
      #1;
      check("mid_rst_wr_en", wr_en, 0);
      check("mid_rst_ready", s_tready, 0);
      check("mid_rst_addr", wr_addr, 0);
      check("mid_rst_idata", idata, 0);
      check("mid_rst_len", pkt_len, 0);
      tick(); tick();
      rst_n = 1'b1;
      clear_logs();
      for (int i = 0; i < 4; i++) send_beat(32'hF000_0000 + i, (i == 3), 4'hF);
      wait_valid();
      check("post_rst_len", pkt_len, 16);
      check("post_rst_nwrites", log_addr.size(), 4);
      if (log_addr.size() > 0) check("post_rst_addr0", log_addr[0], 0);
      do_ack();

      // Back-to-back single-beat packets
      tick();
      clear_logs();
      pkt_ack = 1'b1;
      send_beat(32'hB1B1_B1B1, 1'b1, 4'hF);
      send_beat(32'hB2B2_B2B2, 1'b1, 4'hF);
      repeat (4) tick();
      pkt_ack = 1'b0;
      check("b2b_pulses", pulse_len.size(), 2);
      if (pulse_len.size() == 2) begin
         check("b2b_len0", pulse_len[0], 4);
         check("b2b_len1", pulse_len[1], 4);
      end
      check("b2b_nwrites", log_addr.size(), 2);
      if (log_addr.size() == 2) begin
         check("b2b_addr0", log_addr[0], 0);
         check("b2b_addr1", log_addr[1], 0);
      end

      repeat (3) tick();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/packet_filler.md
# packet_filler

Upstream write-side stage for packet memory. Accepts a 32-bit big-endian word stream (AXI-Stream style), packs each packet into one packet buffer starting at word address 0, and drives the memory's 32-bit write port (`wr_addr`, `idata`, `wr_en`). On packet end it presents the byte length to the buffer-swap/filter side and holds it until acknowledged.

## Interface
- `BYTE_ADDR_WIDTH`, 12: byte address width of one packet buffer.
- `ADDR_WIDTH`, `BYTE_ADDR_WIDTH-2`: word address width; the buffer holds 2^ADDR_WIDTH words.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `s_tdata`  in  32  stream word; byte 0 of the packet is `[31:24]`.
- `s_tvalid`  in  1  stream word valid.
- `s_tready`  out  1  stream word accepted when `s_tvalid & s_tready`.
- `s_tlast`  in  1  last word of the packet.
- `s_tkeep`  in  4  last-beat byte enables; exists only with `PACKET_FILLER_TKEEP_EN`.
- `buf_rdy`  in  1  an empty buffer is attached to the write port.
- `wr_addr`  out  ADDR_WIDTH  word write address.
- `idata`  out  32  write data.
- `wr_en`  out  1  write strobe, one word per cycle.
- `pkt_valid`  out  1  packet complete; `pkt_len` and `pkt_trunc` are valid.
- `pkt_len`  out  BYTE_ADDR_WIDTH+1  packet length in bytes, saturating at 2^BYTE_ADDR_WIDTH.
- `pkt_trunc`  out  1  packet exceeded the buffer; the excess was dropped.
- `pkt_ack`  in  1  consumer has taken the buffer.

## Operation
- States:
  - IDLE: `s_tready=0`. Go to FILL when `buf_rdy=1`.
  - FILL: `s_tready=1`. Each accepted beat writes one word while `word_cnt < 2^ADDR_WIDTH`, then increments `word_cnt`.
    - Beats accepted after the buffer is full are dropped, and `pkt_trunc` is set.
    - An accepted `s_tlast` beat moves to DONE.
  - DONE: `s_tready=0`, `pkt_valid=1`. Go to IDLE on `pkt_ack=1`.
- `word_cnt` is ADDR_WIDTH+1 bits and clears on entry to FILL. Writing is gated, so `wr_addr` never wraps.
- `pkt_len` is `4*words_written`, less unused last-beat bytes (see Configuration), and saturates at 2^BYTE_ADDR_WIDTH. Once truncated, `pkt_len = 2^BYTE_ADDR_WIDTH`.
- A single-beat packet (`s_tlast` on the first beat) is legal.
- `pkt_ack` outside DONE is ignored. `buf_rdy` is sampled only in IDLE.
- Reset mid-packet returns to IDLE. The partial buffer is abandoned and not reported.
- Reset values:
  - state: IDLE
  - `s_tready`: 0
  - `wr_en`: 0
  - `wr_addr`: 0
  - `idata`: 0
  - `pkt_valid`: 0
  - `pkt_len`: 0
  - `pkt_trunc`: 0

## Timing
- `wr_en`, `wr_addr` and `idata` are registered.
  - A beat accepted at edge N appears on the write port during cycle N+1.
  - Throughput is one word per cycle.
- `pkt_valid` rises the cycle after the `s_tlast` handshake, together with the final `wr_en` pulse, so the last word is written no later than the edge at which `pkt_valid` is first sampled high.
- `pkt_len` and `pkt_trunc` are stable while `pkt_valid=1`.
- `pkt_ack` sampled high at edge M:
  - `pkt_valid` drops in cycle M+1.
  - `s_tready` can rise no earlier than M+2, after IDLE sees `buf_rdy`.
- Minimum packet-to-packet gap: 2 cycles with `pkt_ack` and `buf_rdy` held high.

## Configuration
- `PACKET_FILLER_TKEEP_EN` defined:
  - The `s_tkeep` port exists.
  - On the last beat, valid bytes = count of leading ones from bit 3: 1000→1, 1100→2, 1110→3, 1111→4. Non-contiguous patterns count only the leading run, e.g. 1010→1; 0xxx→0.
  - The full word is still written.
  - `s_tkeep` is ignored on non-last beats.
- Undefined: no `s_tkeep` port; every beat counts 4 bytes; `pkt_len` is always a multiple of 4.

## Test plan
- Basic packet: reset, `buf_rdy=1`, stream 3 beats 0x11223344, 0x55667788, 0x99AABBCC with `s_tlast` on the third → writes to addresses 0, 1, 2 on consecutive cycles; `pkt_valid=1`, `pkt_len=12`, `pkt_trunc=0`; no further `s_tready` until `pkt_ack`.
- Tkeep (macro on): 2-beat packet, last `s_tkeep=4'b1100` → `pkt_len=6`. Repeat with `4'b1010` → `pkt_len=5`.
- Overflow (ADDR_WIDTH=10): stream 1030 beats → exactly 1024 `wr_en` pulses at addresses 0..1023, 6 beats accepted but not written; `pkt_len=4096`, `pkt_trunc=1`.
- Backpressure: `buf_rdy=0` for 5 cycles with `s_tvalid=1` → `s_tready=0` and no writes. Raise `buf_rdy` → the first write comes 2 cycles later, at address 0. Random `s_tvalid` gaps produce no duplicate or skipped addresses.
- Reset mid-packet: assert `rst_n=0` after 2 of 4 beats → all outputs at reset values immediately. The next packet starts at address 0 with the correct `pkt_len`.
- Back-to-back: two 1-beat packets with `pkt_ack` and `buf_rdy` tied high → two `pkt_valid` pulses, each `pkt_len=4`, both writes at address 0.
